// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: permutation tables, shift schedule,
// FSM state encoding and C/D rotation helpers.
// Table entries use DES bit numbering (1 = MSB).
package des_pkg;

  localparam int unsigned NUM_ROUNDS = 16;
  localparam int unsigned CD_W       = 56;
  localparam int unsigned SUBKEY_W   = 48;

  // PC-1: output bit i (1..56) takes key bit PC1_TABLE[i-1] (1..64).
  localparam int unsigned PC1_TABLE [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: output bit i (1..48) takes C/D bit PC2_TABLE[i-1] (1..56).
  localparam int unsigned PC2_TABLE [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Left-rotate amount applied to C and D before producing each encrypt subkey.
  localparam int unsigned SHIFT_SCHEDULE [NUM_ROUNDS] = '{
    1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
  };

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFinish
  } state_e;

  // Rotate C and D halves left independently by 1 or 2.
  function automatic logic [CD_W-1:0] cd_rotl(input logic [CD_W-1:0] cd,
                                              input int unsigned    amount);
    logic [27:0] c;
    logic [27:0] d;
    c = cd[55:28];
    d = cd[27:0];
    if (amount == 2) begin
      c = {c[25:0], c[27:26]};
      d = {d[25:0], d[27:26]};
    end else begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    return {c, d};
  endfunction

  // Rotate C and D halves right independently by 1 or 2.
  function automatic logic [CD_W-1:0] cd_rotr(input logic [CD_W-1:0] cd,
                                              input int unsigned    amount);
    logic [27:0] c;
    logic [27:0] d;
    c = cd[55:28];
    d = cd[27:0];
    if (amount == 2) begin
      c = {c[1:0], c[27:2]};
      d = {d[1:0], d[27:2]};
    end else begin
      c = {c[0], c[27:1]};
      d = {d[0], d[27:1]};
    end
    return {c, d};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// DES Permuted Choice 2: 56-bit C/D pair to 48-bit round subkey.
// Pure wiring; vectors are [MSB:0] with DES bit 1 at the MSB.
module des_pc2
  import des_pkg::*;
(
  input  logic [CD_W-1:0]     cd,
  output logic [SUBKEY_W-1:0] subkey
);

  for (genvar i = 0; i < SUBKEY_W; i++) begin : g_pc2
    assign subkey[SUBKEY_W-1-i] = cd[CD_W - PC2_TABLE[i]];
  end

endmodule

// File: rtl/des_key_schedule.sv
// DES key schedule: captures a 64-bit key on start and streams the 16 round
// subkeys over a valid/ready handshake, forward (encrypt) or reversed (decrypt).
// Optional feature macro: DES_KEY_PARITY_CHECK_EN adds the parity_err output,
// flagging any key byte with even parity.
module des_key_schedule
  import des_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                decrypt,
  input  logic [63:0]         key,
  output logic [SUBKEY_W-1:0] subkey,
  output logic                subkey_valid,
  input  logic                subkey_ready,
  output logic [3:0]          round_idx,
  output logic                busy,
  output logic                done
`ifdef DES_KEY_PARITY_CHECK_EN
  ,
  output logic                parity_err
`endif
);

  state_e          state_q, state_d;
  logic [CD_W-1:0] cd_q, cd_d;
  logic [3:0]      idx_q, idx_d;
  logic            decrypt_q, decrypt_d;

  logic [CD_W-1:0] pc1_key;
  logic [3:0]      idx_next;
  logic [3:0]      idx_rev;
  logic            last_round;

  // PC-1 drops the eight parity bits and splits the key into C0 (MSBs) and D0.
  for (genvar i = 0; i < CD_W; i++) begin : g_pc1
    assign pc1_key[CD_W-1-i] = key[64 - PC1_TABLE[i]];
  end

  assign idx_next   = idx_q + 4'd1;
  // Going from K(16-r) down to K(15-r) undoes the shift that produced K(16-r).
  assign idx_rev    = 4'd15 - idx_q;
  assign last_round = (idx_q == 4'(NUM_ROUNDS - 1));

  // Next-state logic: load on start, advance C/D on each accepted subkey.
  always_comb begin
    state_d   = state_q;
    cd_d      = cd_q;
    idx_d     = idx_q;
    decrypt_d = decrypt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          decrypt_d = decrypt;
          idx_d     = '0;
          // Encrypt presents K1 first, so the first left shift is folded into
          // the load; decrypt presents K16 = PC-2(C0,D0) since C16/D16 = C0/D0.
          cd_d      = decrypt ? pc1_key : cd_rotl(pc1_key, SHIFT_SCHEDULE[0]);
          state_d   = StRun;
        end
      end
      StRun: begin
        if (subkey_ready) begin
          if (last_round) begin
            state_d = StFinish;
          end else begin
            idx_d = idx_next;
            cd_d  = decrypt_q ? cd_rotr(cd_q, SHIFT_SCHEDULE[idx_rev])
                              : cd_rotl(cd_q, SHIFT_SCHEDULE[idx_next]);
          end
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset clears C/D so the subkey output reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cd_q      <= '0;
      idx_q     <= '0;
      decrypt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cd_q      <= cd_d;
      idx_q     <= idx_d;
      decrypt_q <= decrypt_d;
    end
  end

  des_pc2 u_pc2 (
    .cd     (cd_q),
    .subkey (subkey)
  );

  // Handshake and status outputs decode directly from the state register.
  always_comb begin
    subkey_valid = (state_q == StRun);
    busy         = (state_q != StIdle);
    done         = (state_q == StFinish);
    round_idx    = idx_q;
  end

`ifdef DES_KEY_PARITY_CHECK_EN
  logic [7:0] byte_even;
  logic       parity_err_q;

  // DES keys use odd parity per byte; XNOR-reduce flags an even byte.
  for (genvar b = 0; b < 8; b++) begin : g_parity
    assign byte_even[b] = ~^key[8*b +: 8];
  end

  // Parity flag is sampled with an accepted start and held until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else if ((state_q == StIdle) && start) begin
      parity_err_q <= |byte_even;
    end
  end

  assign parity_err = parity_err_q;
`else
  // Parity bits 8,16,...,64 never reach PC-1's output.
  logic unused_parity_bits;
  assign unused_parity_bits = ^{key[56], key[48], key[40], key[32],
                                key[24], key[16], key[8],  key[0]};
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule using the classic DES example key.
// Expected subkeys are pushed to a scoreboard at start and popped on transfer.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        decrypt;
  logic [63:0] key;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;
`ifdef DES_KEY_PARITY_CHECK_EN
  logic        parity_err;
`endif

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  // K1..K16 for KEY.
  localparam logic [47:0] KS [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  int checks = 0;
  int passed = 0;
  logic [51:0] sb [$];

  always #5 clk = ~clk;

  des_key_schedule dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .decrypt      (decrypt),
    .key          (key),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round_idx    (round_idx),
    .busy         (busy),
    .done         (done)
`ifdef DES_KEY_PARITY_CHECK_EN
    ,
    .parity_err   (parity_err)
`endif
  );

  task automatic push_expected(input logic dec);
    sb.delete();
    for (int i = 0; i < 16; i++) begin
      sb.push_back({4'(i), dec ? KS[15-i] : KS[i]});
    end
  endtask

  // Called at a negedge; returns at the negedge after the start was sampled.
  task automatic do_start(input logic [63:0] k, input logic dec);
    start   = 1'b1;
    key     = k;
    decrypt = dec;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({subkey_valid, busy, done, round_idx, subkey} !== '0)
      $display("FAIL reset_async: got valid=%b busy=%b done=%b idx=%0d key=%h, required all 0",
               subkey_valid, busy, done, round_idx, subkey);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    subkey_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || subkey_valid !== 1'b0 || round_idx !== 4'd0)
      $display("FAIL ready_idle: got busy=%b valid=%b idx=%0d, required 0 0 0",
               busy, subkey_valid, round_idx);
    else passed++;
    subkey_ready = 1'b0;
  endtask

  task automatic test_schedule(input logic dec);
    int xfers = 0;
    int first_x = -1;
    int last_x = -1;
    int done_cyc = -1;
    logic [51:0] exp;
    push_expected(dec);
    subkey_ready = 1'b1;
    do_start(KEY, dec);
    for (int cyc = 0; cyc < 40 && done_cyc < 0; cyc++) begin
      if (subkey_valid && subkey_ready) begin
        checks++;
        if (sb.size() == 0) begin
          $display("FAIL sched_extra(dec=%b): transfer idx=%0d, required none", dec, round_idx);
        end else begin
          exp = sb.pop_front();
          if ({round_idx, subkey} !== exp)
            $display("FAIL sched_key(dec=%b): got idx=%0d key=%h, required idx=%0d key=%h",
                     dec, round_idx, subkey, exp[51:48], exp[47:0]);
          else passed++;
          xfers++;
          if (first_x < 0) first_x = cyc;
          last_x = cyc;
        end
      end
      if (done === 1'b1) done_cyc = cyc;
      @(negedge clk);
    end
    checks++;
    if (xfers != 16 || first_x != 0 || last_x != 15)
      $display("FAIL sched_consec(dec=%b): got %0d xfers cycles %0d..%0d, required 16 at 0..15",
               dec, xfers, first_x, last_x);
    else passed++;
    checks++;
    if (done_cyc != last_x + 1)
      $display("FAIL sched_done(dec=%b): got done at cycle %0d, required %0d",
               dec, done_cyc, last_x + 1);
    else passed++;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL sched_idle(dec=%b): got done=%b busy=%b, required 0 0", dec, done, busy);
    else passed++;
  endtask

  task automatic test_backpressure();
    bit stalled = 0;
    bit done_seen = 0;
    logic [51:0] held = '0;
    logic [51:0] exp;
    push_expected(1'b0);
    subkey_ready = 1'b0;
    do_start(KEY, 1'b0);
    for (int cyc = 0; cyc < 300 && !done_seen; cyc++) begin
      if (stalled) begin
        checks++;
        if (subkey_valid !== 1'b1 || {round_idx, subkey} !== held)
          $display("FAIL bp_hold: got valid=%b idx=%0d key=%h, required 1 idx=%0d key=%h",
                   subkey_valid, round_idx, subkey, held[51:48], held[47:0]);
        else passed++;
      end
      subkey_ready = (cyc % 3 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      stalled = 0;
      if (subkey_valid) begin
        if (subkey_ready) begin
          checks++;
          if (sb.size() == 0) begin
            $display("FAIL bp_extra: transfer idx=%0d, required none", round_idx);
          end else begin
            exp = sb.pop_front();
            if ({round_idx, subkey} !== exp)
              $display("FAIL bp_key: got idx=%0d key=%h, required idx=%0d key=%h",
                       round_idx, subkey, exp[51:48], exp[47:0]);
            else passed++;
          end
        end else begin
          held = {round_idx, subkey};
          stalled = 1;
        end
      end
      if (done === 1'b1) done_seen = 1;
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0 || !done_seen)
      $display("FAIL bp_complete: got %0d left done_seen=%0d, required 0 left done_seen=1",
               sb.size(), done_seen);
    else passed++;
    subkey_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    subkey_ready = 1'b1;
    do_start(KEY, 1'b0);
    for (int cyc = 0; cyc < 40 && !found; cyc++) begin
      if (subkey_valid === 1'b1 && round_idx === 4'd7) found = 1;
      else @(negedge clk);
    end
    checks++;
    if (!found) $display("FAIL rst_mid_reach: got no idx=7, required idx=7 within 40 cycles");
    else passed++;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({subkey_valid, busy, done, round_idx, subkey} !== '0)
      $display("FAIL rst_mid_clear: got valid=%b busy=%b done=%b idx=%0d key=%h, required all 0",
               subkey_valid, busy, done, round_idx, subkey);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || subkey_valid !== 1'b0)
      $display("FAIL rst_mid_resume: got busy=%b valid=%b, required 0 0", busy, subkey_valid);
    else passed++;
    do_start(KEY, 1'b0);
    checks++;
    if (subkey_valid !== 1'b1 || round_idx !== 4'd0 || subkey !== KS[0])
      $display("FAIL rst_mid_restart: got valid=%b idx=%0d key=%h, required 1 0 %h",
               subkey_valid, round_idx, subkey, KS[0]);
    else passed++;
    for (int cyc = 0; cyc < 40 && busy; cyc++) @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL rst_mid_drain: got busy=%b, required 0", busy);
    else passed++;
  endtask

  task automatic test_start_busy();
    bit injected = 0;
    bit done_seen = 0;
    logic [51:0] exp;
    push_expected(1'b0);
    subkey_ready = 1'b1;
    do_start(KEY, 1'b0);
    for (int cyc = 0; cyc < 40 && !done_seen; cyc++) begin
      start   = 1'b0;
      key     = KEY;
      decrypt = 1'b0;
      if (subkey_valid && subkey_ready) begin
        checks++;
        if (sb.size() == 0) begin
          $display("FAIL busy_extra: transfer idx=%0d, required none", round_idx);
        end else begin
          exp = sb.pop_front();
          if ({round_idx, subkey} !== exp)
            $display("FAIL busy_key: got idx=%0d key=%h, required idx=%0d key=%h",
                     round_idx, subkey, exp[51:48], exp[47:0]);
          else passed++;
        end
      end
      if (!injected && subkey_valid === 1'b1 && round_idx === 4'd3) begin
        start    = 1'b1;
        key      = 64'h0;
        decrypt  = 1'b1;
        injected = 1;
      end
      if (done === 1'b1) done_seen = 1;
      @(negedge clk);
    end
    start = 1'b0;
    key   = KEY;
    checks++;
    if (sb.size() != 0 || !injected || !done_seen)
      $display("FAIL busy_complete: got %0d left inj=%0d done=%0d, required 0 1 1",
               sb.size(), injected, done_seen);
    else passed++;
  endtask

  task automatic test_back_to_back();
    subkey_ready = 1'b1;
    do_start(KEY, 1'b0);
    for (int cyc = 0; cyc < 40 && done !== 1'b1; cyc++) @(negedge clk);
    checks++;
    if (done !== 1'b1) $display("FAIL b2b_done: got done=%b, required 1", done);
    else passed++;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL b2b_idle: got busy=%b, required 0", busy);
    else passed++;
    do_start(KEY, 1'b1);
    checks++;
    if (subkey_valid !== 1'b1 || round_idx !== 4'd0 || subkey !== KS[15])
      $display("FAIL b2b_restart: got valid=%b idx=%0d key=%h, required 1 0 %h",
               subkey_valid, round_idx, subkey, KS[15]);
    else passed++;
    for (int cyc = 0; cyc < 40 && busy; cyc++) @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL b2b_drain: got busy=%b, required 0", busy);
    else passed++;
  endtask

`ifdef DES_KEY_PARITY_CHECK_EN
  task automatic test_parity();
    int xfers = 0;
    subkey_ready = 1'b1;
    do_start(KEY, 1'b0);
    checks++;
    if (parity_err !== 1'b0) $display("FAIL parity_good: got %b, required 0", parity_err);
    else passed++;
    for (int cyc = 0; cyc < 40 && busy; cyc++) @(negedge clk);
    do_start(64'h0, 1'b0);
    checks++;
    if (parity_err !== 1'b1) $display("FAIL parity_bad: got %b, required 1", parity_err);
    else passed++;
    for (int cyc = 0; cyc < 40 && busy; cyc++) begin
      if (subkey_valid && subkey_ready) xfers++;
      @(negedge clk);
    end
    checks++;
    if (xfers != 16 || parity_err !== 1'b1)
      $display("FAIL parity_run: got %0d xfers err=%b, required 16 1", xfers, parity_err);
    else passed++;
  endtask
`endif

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    decrypt      = 1'b0;
    key          = '0;
    subkey_ready = 1'b0;
    test_reset();
    test_schedule(1'b0);
    test_schedule(1'b1);
    test_backpressure();
    test_reset_mid();
    test_start_busy();
    test_back_to_back();
`ifdef DES_KEY_PARITY_CHECK_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
